// File: rtl/multi_delay_pkg.sv
// Shared types and elaboration helpers for the multi-channel delay timer.
package multi_delay_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int unsigned MAX_CBITS = 31;

    // True when a reset limit of n is representable in a cbits-wide counter.
    function automatic bit limit_fits(input int unsigned cbits, input longint unsigned n);
        return (cbits >= 1) && (cbits <= MAX_CBITS) && (n < (64'd1 << cbits));
    endfunction

endpackage

// File: rtl/multi_delay_timer_channel.sv
// One programmable delay channel: IDLE/RUN FSM, counter, active limit and a
// shadow limit that is only applied when the count is at (or returns to) zero.
module delay_channel
    import multi_delay_pkg::*;
#(
    parameter int unsigned CBITS     = 15,
    parameter int unsigned DEFAULT_N = 17500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             periodic,
    input  logic             ld_we,
    input  logic [CBITS-1:0] ld_val,
    output logic             busy,
    output logic             expire,
    output logic             over
);

    chan_state_e      state;
    chan_state_e      state_nx;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] lim;
    logic [CBITS-1:0] shadow;
    logic             pend;
    logic             mode;
    logic             reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !abort) state_nx = RUN;
            RUN: begin
                if (abort)                state_nx = IDLE;
                else if (start)           state_nx = RUN;
                else if (expire && !mode) state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        expire = busy && (cnt == lim);
        over   = (cnt > lim);
    end

    // Edges at which cnt becomes 0 next; only these may swap in a new limit.
    assign reload = !busy || abort || start || expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            lim    <= CBITS'(DEFAULT_N);
            shadow <= CBITS'(DEFAULT_N);
            pend   <= 1'b0;
            mode   <= 1'b0;
        end else begin
            if (busy && !(abort || start || expire)) cnt <= cnt + CBITS'(1);
            else                                     cnt <= '0;
            if (start && !abort) mode <= periodic;
            if (ld_we) shadow <= ld_val;
            if (pend && reload) lim <= shadow;
            if (ld_we)       pend <= 1'b1;
            else if (reload) pend <= 1'b0;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !busy |-> (cnt == '0));

endmodule

// File: rtl/multi_delay_timer.sv
// NCH independent programmable delay channels with per-channel limit load,
// plus aggregated over-limit error and all-idle summary.
module multi_delay_timer
    import multi_delay_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CBITS     = 15,
    parameter int unsigned DEFAULT_N = 17500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         abort,
    input  logic [NCH-1:0]         periodic,
    input  logic                   ld_en,
    input  logic [$clog2(NCH)-1:0] ld_ch,
    input  logic [CBITS-1:0]       ld_val,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         expire,
    output logic                   err,
    output logic                   idle
);

    localparam bit DEFAULT_OK = limit_fits(CBITS, DEFAULT_N);

    if (!DEFAULT_OK) begin : g_bad_default
        $error("multi_delay_timer: DEFAULT_N does not fit in CBITS");
    end

    logic [NCH-1:0] over;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ld_we;
        // Selects outside 0..NCH-1 match no channel and are dropped.
        assign ld_we = ld_en && (int'(ld_ch) == i);

        delay_channel #(
            .CBITS    (CBITS),
            .DEFAULT_N(DEFAULT_N)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .start   (start[i]),
            .abort   (abort[i]),
            .periodic(periodic[i]),
            .ld_we   (ld_we),
            .ld_val  (ld_val),
            .busy    (busy[i]),
            .expire  (expire[i]),
            .over    (over[i])
        );
    end

    assign err  = |over;
    assign idle = ~|busy;

    assert property (@(posedge clk) disable iff (rst) !err);
    assert property (@(posedge clk) disable iff (rst) (expire & ~busy) == '0);

endmodule

// File: tb/tb_multi_delay_timer.sv
// Scoreboard bench for multi_delay_timer: expected expire events are queued as
// stimulus is driven and matched against the DUT after every clock edge.
module tb_multi_delay_timer;

    localparam int unsigned NCH       = 4;
    localparam int unsigned CBITS     = 15;
    localparam int unsigned DEFAULT_N = 17500;
    localparam int unsigned CHW       = $clog2(NCH);

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   abort;
    logic [NCH-1:0]   periodic;
    logic             ld_en;
    logic [CHW-1:0]   ld_ch;
    logic [CBITS-1:0] ld_val;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   expire;
    logic             err;
    logic             idle;

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;
    bit sb_on  = 1'b1;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    multi_delay_timer #(
        .NCH      (NCH),
        .CBITS    (CBITS),
        .DEFAULT_N(DEFAULT_N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .periodic(periodic),
        .ld_en   (ld_en),
        .ld_ch   (ld_ch),
        .ld_val  (ld_val),
        .busy    (busy),
        .expire  (expire),
        .err     (err),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input int ch, input int cyc);
        ev_t e;
        e.ch  = ch;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // One rising edge, then inspect outputs on the following falling edge.
    task automatic step();
        int idx;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err edge=%0d got=%b exp=0", edge_n, err);
        end
        tests++;
        if (idle !== ~|busy) begin
            fails++;
            $display("FAIL idle edge=%0d got=%b exp=%b", edge_n, idle, ~|busy);
        end
        tests++;
        if ((expire & ~busy) !== '0) begin
            fails++;
            $display("FAIL expire_busy edge=%0d expire=%b busy=%b", edge_n, expire, busy);
        end
        if (sb_on) begin
            for (int ch = 0; ch < int'(NCH); ch++) begin
                if (expire[ch] !== 1'b0) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (exp_q[k].ch == ch && exp_q[k].cyc == edge_n) idx = k;
                    tests++;
                    if (idx < 0) begin
                        fails++;
                        $display("FAIL expire_unexpected ch=%0d edge=%0d got=%b exp=0", ch, edge_n, expire[ch]);
                    end else begin
                        exp_q.delete(idx);
                    end
                end
            end
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].cyc <= edge_n) begin
                    tests++;
                    fails++;
                    $display("FAIL expire_missing ch=%0d edge=%0d got=0 exp=1", exp_q[k].ch, exp_q[k].cyc);
                    exp_q.delete(k);
                end
            end
        end
    endtask

    task automatic drain_check(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_busy(input string name, input int ch, input logic exp);
        tests++;
        if (busy[ch] !== exp) begin
            fails++;
            $display("FAIL %s busy[%0d] got=%b exp=%b", name, ch, busy[ch], exp);
        end
    endtask

    // Write a limit while the channel is idle; the extra edge applies it.
    task automatic load_lim(input int ch, input int val);
        ld_en  = 1'b1;
        ld_ch  = CHW'(ch);
        ld_val = CBITS'(val);
        step();
        ld_en  = 1'b0;
        step();
    endtask

    task automatic start_ch(input int ch, input logic per);
        start[ch]    = 1'b1;
        periodic[ch] = per;
        step();
        start[ch]    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++;
        if (busy !== '0 || expire !== '0 || err !== 1'b0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_state busy=%b expire=%b err=%b idle=%b exp busy=0 expire=0 err=0 idle=1",
                     busy, expire, err, idle);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_default_oneshot();
        int t;
        t = edge_n + 1;
        expect_ev(0, t + int'(DEFAULT_N));
        start_ch(0, 1'b0);
        check_busy("default_run", 0, 1'b1);
        repeat (DEFAULT_N) step();
        step();
        check_busy("default_done", 0, 1'b0);
        drain_check("default");
    endtask

    task automatic test_reset_midrun();
        start_ch(0, 1'b0);
        repeat (9) step();
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== '0 || expire !== '0 || idle !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset busy=%b expire=%b idle=%b err=%b exp busy=0 expire=0 idle=1 err=0",
                     busy, expire, idle, err);
        end
        step();
        rst = 1'b0;
        load_lim(0, 4);
        expect_ev(0, edge_n + 1 + 4);
        start_ch(0, 1'b0);
        repeat (5) step();
        check_busy("midrun_restart_done", 0, 1'b0);
        drain_check("midrun");
    endtask

    task automatic test_periodic_reload();
        int t;
        load_lim(1, 3);
        t = edge_n + 1;
        expect_ev(1, t + 3);
        expect_ev(1, t + 7);
        expect_ev(1, t + 9);
        expect_ev(1, t + 11);
        start_ch(1, 1'b1);
        repeat (4) step();
        // Two loads back to back before the next expiry: the last one wins.
        ld_en = 1'b1; ld_ch = CHW'(1); ld_val = CBITS'(2);
        step();
        ld_val = CBITS'(1);
        step();
        ld_en = 1'b0;
        repeat (5) step();
        abort[1] = 1'b1;
        step();
        abort[1] = 1'b0;
        check_busy("periodic_abort", 1, 1'b0);
        drain_check("periodic");
    endtask

    task automatic test_lim_zero();
        int t;
        load_lim(2, 0);
        t = edge_n + 1;
        for (int k = 0; k < 6; k++) expect_ev(2, t + k);
        start_ch(2, 1'b1);
        repeat (5) step();
        abort[2] = 1'b1;
        step();
        abort[2] = 1'b0;
        tests++;
        if (expire[2] !== 1'b0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL lim0_abort expire2=%b idle=%b exp expire2=0 idle=1", expire[2], idle);
        end
        expect_ev(2, edge_n + 1);
        start_ch(2, 1'b0);
        step();
        check_busy("lim0_oneshot_done", 2, 1'b0);
        drain_check("lim0");
    endtask

    task automatic test_ch3_events();
        int t;
        load_lim(3, 5);
        start[3] = 1'b1;
        abort[3] = 1'b1;
        step();
        start[3] = 1'b0;
        abort[3] = 1'b0;
        tests++;
        if (busy[3] !== 1'b0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL abort_start busy3=%b idle=%b exp busy3=0 idle=1", busy[3], idle);
        end
        t = edge_n + 1;
        expect_ev(3, t + 5);
        expect_ev(3, t + 11);
        start_ch(3, 1'b0);
        repeat (5) step();
        start_ch(3, 1'b0);
        check_busy("restart_at_expiry", 3, 1'b1);
        repeat (5) step();
        step();
        check_busy("restart_done", 3, 1'b0);
        drain_check("ch3");
    endtask

    task automatic test_random();
        sb_on = 1'b0;
        for (int n = 0; n < 40000; n++) begin
            for (int ch = 0; ch < int'(NCH); ch++) begin
                start[ch]    = ($urandom_range(7) == 0);
                abort[ch]    = ($urandom_range(31) == 0);
                periodic[ch] = $urandom_range(1) == 1;
            end
            ld_en  = ($urandom_range(15) == 0);
            ld_ch  = CHW'($urandom_range(NCH - 1));
            ld_val = ($urandom_range(63) == 0) ? CBITS'($urandom) : CBITS'($urandom_range(40));
            step();
        end
        start = '0;
        ld_en = 1'b0;
        abort = '1;
        step();
        abort = '0;
        tests++;
        if (idle !== 1'b1) begin
            fails++;
            $display("FAIL random_final_idle got=%b exp=1", idle);
        end
        sb_on = 1'b1;
    endtask

    initial begin
        start    = '0;
        abort    = '0;
        periodic = '0;
        ld_en    = 1'b0;
        ld_ch    = '0;
        ld_val   = '0;
        test_reset();
        test_default_oneshot();
        test_reset_midrun();
        test_periodic_reload();
        test_lim_zero();
        test_ch3_events();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
